tcu_uop_dispatch: RTL and testbench

Issue-side controller directly upstream of the TCU micro-op expander. It accepts instruction-buffer entries over a valid/ready handshake and forwards non-TCU entries unchanged. For each TCU entry it holds the entry, drives the expander's start/next/done protocol, and emits the expander's micro-ops one per cycle into a registered output slot. It stalls the input until the last micro-op has been taken.

---
 rtl/tcu_uop_dispatch.sv | 117 +++++++++++
 tb/tb_tcu_uop_dispatch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_uop_dispatch.sv
// rtl/tcu_uop_dispatch.sv - issue-side dispatcher feeding the TCU micro-op expander
module tcu_uop_dispatch #(
  parameter int              TCU_UOPS  = 8,
  parameter int              DATA_W    = 64,
  parameter int              EX_LSB    = 0,
  parameter int              EX_W      = 3,
  parameter logic [EX_W-1:0] EX_TCU_ID = EX_W'(5),
  localparam int             IDX_W     = $clog2(TCU_UOPS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] exp_ibuf,
  output logic              exp_start,
  output logic              exp_next,
  input  logic [DATA_W-1:0] exp_uop,
  input  logic              exp_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [IDX_W-1:0]  uop_idx
);

  typedef enum logic [1:0] {IDLE, START, EXPAND} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   hold_q;
  logic                slot_free;
  logic                slot_load;
  logic [DATA_W-1:0]   slot_src;
  logic                hold_load;
  logic                is_tcu;
  logic                in_fire;

  // The output slot can take a new entry when it is empty or being drained this cycle.
  assign slot_free = ~out_valid | out_ready;
  assign is_tcu    = (in_data[EX_LSB +: EX_W] == EX_TCU_ID);
  assign exp_ibuf  = hold_q;
  assign busy      = (state != IDLE);

  // Next-state and handshake decode; everything is gated by reset so nothing fires while held.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    exp_start = 1'b0;
    exp_next  = 1'b0;
    slot_load = 1'b0;
    slot_src  = in_data;
    hold_load = 1'b0;
    in_fire   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = slot_free & reset;
        in_fire  = in_valid & slot_free & reset;
        if (in_fire) begin
          if (is_tcu) begin
            hold_load = 1'b1;
            state_nxt = START;
          end else begin
            slot_load = 1'b1;
          end
        end
      end
      START: begin
        exp_start = reset;
        state_nxt = EXPAND;
      end
      EXPAND: begin
        exp_next = slot_free & reset;
        if (exp_next) begin
          slot_load = 1'b1;
          slot_src  = exp_uop;
          if (exp_done) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any expansion in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Output slot valid: set on load, cleared when drained without a replacement.
  always_ff @(posedge clk) begin
    if (!reset)         out_valid <= 1'b0;
    else if (slot_load) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Output slot payload; only written on a load so backpressure freezes it.
  always_ff @(posedge clk) begin
    if (slot_load) out_data <= slot_src;
  end

  // Held TCU entry presented to the expander for the whole expansion.
  always_ff @(posedge clk) begin
    if (hold_load) hold_q <= in_data;
  end

  // Micro-ops emitted for the current instruction, saturating at the full count.
  always_ff @(posedge clk) begin
    if (!reset)
      uop_idx <= '0;
    else if (exp_start)
      uop_idx <= '0;
    else if (exp_next && (uop_idx != IDX_W'(TCU_UOPS)))
      uop_idx <= uop_idx + 1'b1;
  end

endmodule

// File: tb/tb_tcu_uop_dispatch.sv
// tb/tb_tcu_uop_dispatch.sv - bench for tcu_uop_dispatch with expander model and scoreboard
module tb_tcu_uop_dispatch;

  localparam logic [2:0] EX_TCU = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [2];
  logic [63:0] in_data   [2];
  logic        in_ready  [2];
  logic [63:0] exp_ibuf  [2];
  logic        exp_start [2];
  logic        exp_next  [2];
  logic [63:0] exp_uop   [2];
  logic        exp_done  [2];
  logic        out_valid [2];
  logic [63:0] out_data  [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [3:0]  uop_idx0;
  logic [0:0]  uop_idx1;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          e_act [2];
  int          e_idx [2];
  logic [63:0] fifo  [2][0:255];
  int          wp [2];
  int          rp [2];
  bit          acc [2];

  always #5 clk = ~clk;

  tcu_uop_dispatch #(.TCU_UOPS(8), .DATA_W(64), .EX_LSB(0), .EX_W(3), .EX_TCU_ID(EX_TCU)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .exp_ibuf(exp_ibuf[0]), .exp_start(exp_start[0]), .exp_next(exp_next[0]), .exp_uop(exp_uop[0]),
    .exp_done(exp_done[0]), .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .uop_idx(uop_idx0));

  tcu_uop_dispatch #(.TCU_UOPS(1), .DATA_W(64), .EX_LSB(0), .EX_W(3), .EX_TCU_ID(EX_TCU)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .exp_ibuf(exp_ibuf[1]), .exp_start(exp_start[1]), .exp_next(exp_next[1]), .exp_uop(exp_uop[1]),
    .exp_done(exp_done[1]), .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .uop_idx(uop_idx1));

  function automatic int nuops(input int g);
    return (g == 0) ? 8 : 1;
  endfunction

  function automatic logic [63:0] uop_of(input logic [63:0] d, input int k);
    return d ^ (64'(k + 1) << 40);
  endfunction

  function automatic logic [63:0] rnd_entry(input bit tcu);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[2:0] = tcu ? EX_TCU : 3'($urandom_range(0, 4));
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Expander model: start arms index 0, each next advances, the last micro-op flags done.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset) begin
        e_act[g] <= 1'b0;
        e_idx[g] <= 0;
      end else if (exp_start[g]) begin
        e_act[g] <= 1'b1;
        e_idx[g] <= 0;
      end else if (exp_next[g]) begin
        e_idx[g] <= e_idx[g] + 1;
        if (e_idx[g] == nuops(g) - 1) e_act[g] <= 1'b0;
      end
    end
  end

  assign exp_uop[0]  = uop_of(exp_ibuf[0], e_idx[0]);
  assign exp_uop[1]  = uop_of(exp_ibuf[1], e_idx[1]);
  assign exp_done[0] = e_act[0] && (e_idx[0] == 7);
  assign exp_done[1] = e_act[1] && (e_idx[1] == 0);

  // Transaction scoreboard: every accepted entry expands to its expected output stream.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset) begin
        rp[g] = wp[g];
      end else begin
        check("start_and_next", 64'(exp_start[g] & exp_next[g]), 0);
        check("next_without_uop", 64'(exp_next[g] & ~e_act[g]), 0);
        if (out_valid[g] && out_ready[g]) begin
          check("sb_unexpected_out", 64'(wp[g] != rp[g]), 1);
          if (wp[g] != rp[g]) begin
            check("sb_data", out_data[g], fifo[g][rp[g] % 256]);
            rp[g] = rp[g] + 1;
          end
        end
        if (in_valid[g] && in_ready[g]) begin
          if (in_data[g][2:0] == EX_TCU) begin
            for (int k = 0; k < nuops(g); k++) begin
              fifo[g][wp[g] % 256] = uop_of(in_data[g], k);
              wp[g] = wp[g] + 1;
            end
          end else begin
            fifo[g][wp[g] % 256] = in_data[g];
            wp[g] = wp[g] + 1;
          end
        end
      end
    end
  end

  task automatic tcu_run(input logic [63:0] d, input int bp_lo, input int bp_hi, input int stop_k,
                         input bit follow_en, input logic [63:0] follow, output int got, output int last_t);
    int k;
    k = 0;
    last_t = -1;
    nxt();
    in_valid[0] = 1'b1; in_data[0] = d; out_ready[0] = 1'b1;
    #1;
    check("tcu_accept_ready", 64'(in_ready[0]), 1);
    for (int t = 1; t < 40 && k < 8 && k != stop_k; t++) begin
      nxt();
      in_valid[0] = 1'b0;
      out_ready[0] = !(t >= bp_lo && t <= bp_hi);
      #1;
      if (t == 1) begin
        check("start_pulse", 64'(exp_start[0]), 1);
        check("start_in_ready", 64'(in_ready[0]), 0);
        check("start_busy", 64'(busy[0]), 1);
      end else if (t == 2) begin
        check("expand0_start", 64'(exp_start[0]), 0);
        check("expand0_out_valid", 64'(out_valid[0]), 0);
        check("expand0_next", 64'(exp_next[0]), 1);
        check("expand0_uop_idx", 64'(uop_idx0), 0);
      end else begin
        check("uop_valid", 64'(out_valid[0]), 1);
        check("uop_data", out_data[0], uop_of(d, k));
        check("uop_idx", 64'(uop_idx0), k + 1);
        check("uop_start_low", 64'(exp_start[0]), 0);
        check("uop_next", 64'(exp_next[0]), 64'(out_ready[0] && k < 7));
        check("uop_in_ready", 64'(in_ready[0]), 64'(k == 7 && out_ready[0]));
        check("uop_busy", 64'(busy[0]), 64'(k != 7));
        if (out_ready[0]) begin
          if (k == 7) begin
            last_t = t;
            if (follow_en) begin
              in_valid[0] = 1'b1;
              in_data[0] = follow;
            end
          end
          k++;
        end
      end
    end
    got = k;
  endtask

  initial begin
    logic [63:0] e [4];
    logic [63:0] d;
    logic [63:0] f;
    int got;
    int last_t;

    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b1; in_data[g] = rnd_entry(1); out_ready[g] = 1'b1;
      wp[g] = 0; rp[g] = 0; acc[g] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      #1;
      for (int g = 0; g < 2; g++) begin
        check("rst_out_valid", 64'(out_valid[g]), 0);
        check("rst_in_ready", 64'(in_ready[g]), 0);
        check("rst_exp_start", 64'(exp_start[g]), 0);
        check("rst_busy", 64'(busy[g]), 0);
      end
    end
    check("rst_uop_idx", 64'(uop_idx0), 0);
    nxt();
    reset = 1'b1; in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    #1;
    check("post_rst_in_ready0", 64'(in_ready[0]), 1);
    check("post_rst_in_ready1", 64'(in_ready[1]), 1);

    for (int i = 0; i < 4; i++) e[i] = rnd_entry(0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      in_valid[0] = (i < 4);
      if (i < 4) in_data[0] = e[i];
      #1;
      if (i < 4) check("pass_in_ready", 64'(in_ready[0]), 1);
      check("pass_no_start", 64'(exp_start[0]), 0);
      if (i > 0) begin
        check("pass_out_valid", 64'(out_valid[0]), 1);
        check("pass_out_data", out_data[0], e[i-1]);
      end
    end

    d = rnd_entry(1);
    f = rnd_entry(0);
    tcu_run(d, 99, 99, 99, 1'b1, f, got, last_t);
    check("tcu8_count", 64'(got), 8);
    check("tcu8_last_cycle", 64'(last_t), 10);
    nxt();
    in_valid[0] = 1'b0;
    #1;
    check("follow_valid", 64'(out_valid[0]), 1);
    check("follow_data", out_data[0], f);

    tcu_run(rnd_entry(1), 4, 6, 99, 1'b0, f, got, last_t);
    check("bp_count", 64'(got), 8);
    check("bp_last_cycle", 64'(last_t), 13);

    nxt();
    in_valid[1] = 1'b1; d = rnd_entry(1); in_data[1] = d;
    #1;
    check("n1_accept", 64'(in_ready[1]), 1);
    nxt(); in_valid[1] = 1'b0; #1;
    check("n1_start", 64'(exp_start[1]), 1);
    nxt(); #1;
    check("n1_expand_busy", 64'(busy[1]), 1);
    check("n1_expand_next", 64'(exp_next[1]), 1);
    nxt(); #1;
    check("n1_out_valid", 64'(out_valid[1]), 1);
    check("n1_out_data", out_data[1], uop_of(d, 0));
    check("n1_busy_fall", 64'(busy[1]), 0);
    check("n1_uop_idx", 64'(uop_idx1), 1);
    nxt(); #1;
    check("n1_single", 64'(out_valid[1]), 0);

    tcu_run(rnd_entry(1), 99, 99, 4, 1'b0, f, got, last_t);
    check("abort_progress", 64'(got), 4);
    nxt();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid[0]), 0);
    check("abort_busy", 64'(busy[0]), 0);
    tcu_run(rnd_entry(1), 99, 99, 99, 1'b0, f, got, last_t);
    check("after_abort_count", 64'(got), 8);

    for (int c = 0; c < 800; c++) begin
      nxt();
      for (int g = 0; g < 2; g++) begin
        if (!in_valid[g] || acc[g]) begin
          in_valid[g] = ($urandom_range(0, 3) != 0);
          in_data[g] = rnd_entry($urandom_range(0, 2) == 0);
        end
        out_ready[g] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int g = 0; g < 2; g++) acc[g] = in_valid[g] && in_ready[g];
    end

    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
    end
    repeat (30) nxt();
    for (int g = 0; g < 2; g++) begin
      check("drain_outstanding", 64'(wp[g] - rp[g]), 0);
      check("drain_busy", 64'(busy[g]), 0);
      check("drain_out_valid", 64'(out_valid[g]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
